// File: rtl/priority_encoder_pipe.sv
`default_nettype none
// ============================================================================
// Module   : priority_encoder_pipe
// Brief    : N-to-log2(N) priority encoder with a registered result stage and
//            a valid/ready handshake. The highest set request bit wins, and an
//            all-zero request is a valid transaction reported with any = 0.
// Options  : PRIORITY_ENCODER_ROUND_ROBIN_EN -- when defined, priority rotates.
//            The search starts just below the previous winner and wraps around.
// Revision : 1.0 - initial release
// ============================================================================
module priority_encoder_pipe #(
  parameter  int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] req,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] idx,
  output logic         any
);

  // --------------------------------------------------------------------------
  // Result stage registers
  // --------------------------------------------------------------------------
  logic         r_valid;
  logic [W-1:0] r_idx;
  logic         r_any;

  // --------------------------------------------------------------------------
  // Handshake
  // --------------------------------------------------------------------------
  logic w_accept;

  // The stage accepts a new input in the same cycle its current result drains.
  assign in_ready = !r_valid || out_ready;
  assign w_accept = in_valid && in_ready;

  // --------------------------------------------------------------------------
  // Search vector
  // In round-robin mode the request is rotated so that position N-1 of the
  // search vector holds req[ptr-1] and position 0 holds req[ptr]. An MSB-first
  // search over the rotated vector then visits ptr-1, ptr-2, ..., wrapping
  // through N-1 and ending at ptr. W-bit index arithmetic wraps modulo N
  // because N is a power of two.
  // --------------------------------------------------------------------------
  logic [N-1:0] w_search;
  logic [W-1:0] w_winner;

`ifdef PRIORITY_ENCODER_ROUND_ROBIN_EN
  logic [W-1:0] r_ptr;

  for (genvar j = 0; j < N; j++) begin : g_rot
    assign w_search[j] = req[W'(j) + r_ptr];
  end
`else
  assign w_search = req;
`endif

  // --------------------------------------------------------------------------
  // MSB-first priority tree (heap layout)
  // Node 1 is the root, and nodes N..2N-1 are the leaves, where leaf N+i is
  // search bit i. Each internal node n merges children 2n (lower half) and
  // 2n+1 (upper half). The upper child wins whenever it holds any set bit, so
  // the logic depth is log2(N) mux levels.
  // --------------------------------------------------------------------------
  logic [2*N-1:1] w_tv;
  logic [W-1:0]   w_tix [1:2*N-1];

  for (genvar i = 0; i < N; i++) begin : g_leaf
    assign w_tv[N+i]  = w_search[i];
    assign w_tix[N+i] = W'(i);
  end

  for (genvar n = 1; n < N; n++) begin : g_node
    assign w_tv[n]  = w_tv[2*n] | w_tv[2*n+1];
    assign w_tix[n] = w_tv[2*n+1] ? w_tix[2*n+1] : w_tix[2*n];
  end

  // When nothing is set, the root index falls through to the lowest leaf, which
  // is 0 in fixed mode. Rotated results are forced to 0 explicitly.
`ifdef PRIORITY_ENCODER_ROUND_ROBIN_EN
  assign w_winner = w_tv[1] ? (w_tix[1] + r_ptr) : '0;
`else
  assign w_winner = w_tix[1];
`endif

  // --------------------------------------------------------------------------
  // Result register: load on accept, clear valid on drain, otherwise hold.
  // --------------------------------------------------------------------------
  // Output stage update; reset discards any pending result.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_idx   <= '0;
      r_any   <= 1'b0;
    end else if (w_accept) begin
      r_valid <= 1'b1;
      r_idx   <= w_winner;
      r_any   <= |req;
    end else if (r_valid && out_ready) begin
      r_valid <= 1'b0;
    end
  end

`ifdef PRIORITY_ENCODER_ROUND_ROBIN_EN
  // The pointer follows the last winner; empty requests leave it in place.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (w_accept && (|req)) begin
      r_ptr <= w_winner;
    end
  end
`endif

  assign out_valid = r_valid;
  assign idx       = r_idx;
  assign any       = r_any;

endmodule
`default_nettype wire

// File: tb/tb_priority_encoder_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_priority_encoder_pipe
// Brief    : Directed self-checking bench for priority_encoder_pipe (N = 8).
//            The fixed-mode or round-robin vectors are selected with
//            PRIORITY_ENCODER_ROUND_ROBIN_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_priority_encoder_pipe;

  localparam int N = 8;
  localparam int W = 3;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] req;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] idx;
  logic         any;

  int checks;
  int errors;

  priority_encoder_pipe #(.N(N)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .req       (req),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .idx       (idx),
    .any       (any)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value.
  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock edge, then settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply one request, take the edge, and check the registered result.
  task automatic send(input logic [N-1:0] r, input logic [W-1:0] exp_idx,
                      input logic exp_any, input string tag);
    req      = r;
    in_valid = 1'b1;
    tick();
    check_val({tag, "_valid"}, 32'(out_valid), 32'd1);
    check_val({tag, "_idx"},   32'(idx),       32'(exp_idx));
    check_val({tag, "_any"},   32'(any),       32'(exp_any));
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    in_valid  = 1'b1;
    req       = 8'hFF;
    out_ready = 1'b1;

    // Reset held for two cycles while a request is offered.
    tick();
    tick();
    check_val("rst_valid", 32'(out_valid), 32'd0);
    check_val("rst_idx",   32'(idx),       32'd0);
    check_val("rst_any",   32'(any),       32'd0);
    rst      = 1'b0;
    in_valid = 1'b0;
    #1;
    check_val("rst_in_ready", 32'(in_ready), 32'd1);

    // Basic encode cases.
    send(8'b0010_0100, 3'd5, 1'b1, "basic_24");
    send(8'h00,        3'd0, 1'b0, "basic_00");
`ifndef PRIORITY_ENCODER_ROUND_ROBIN_EN
    send(8'h0F,        3'd3, 1'b1, "basic_0f");
    send(8'h55,        3'd6, 1'b1, "basic_55");

    // Back-to-back transfers with no bubble.
    send(8'h80, 3'd7, 1'b1, "b2b_80");
    send(8'h02, 3'd1, 1'b1, "b2b_02");
    send(8'h10, 3'd4, 1'b1, "b2b_10");
`endif

    // Drain without a new input clears out_valid while keeping the data.
    in_valid = 1'b0;
    tick();
    check_val("drain_valid", 32'(out_valid), 32'd0);

    // Backpressure hold.
    rst = 1'b1; tick(); rst = 1'b0;
    send(8'h20, 3'd5, 1'b1, "bp_cap");
    out_ready = 1'b0;
    req       = 8'h01;
    #1;
    check_val("bp_in_ready", 32'(in_ready), 32'd0);
    for (int c = 0; c < 3; c++) begin
      tick();
      check_val("bp_hold_idx",   32'(idx),       32'd5);
      check_val("bp_hold_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    #1;
    check_val("bp_rel_in_ready", 32'(in_ready), 32'd1);
    tick();
    check_val("bp_rel_idx",   32'(idx),       32'd0);
    check_val("bp_rel_any",   32'(any),       32'd1);
    check_val("bp_rel_valid", 32'(out_valid), 32'd1);

    // Reset during a hold discards the pending result.
    send(8'h20, 3'd5, 1'b1, "bp_cap2");
    out_ready = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    check_val("bp_rst_valid", 32'(out_valid), 32'd0);
    check_val("bp_rst_idx",   32'(idx),       32'd0);
    rst       = 1'b0;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    tick();

`ifdef PRIORITY_ENCODER_ROUND_ROBIN_EN
    // Full request rotates through 7..0 and wraps back to 7.
    rst = 1'b1; tick(); rst = 1'b0;
    for (int k = 0; k < 9; k++) begin
      send(8'hFF, W'((15 - k) % 8), 1'b1, "rr_ff");
    end
    // Two requesters alternate.
    rst = 1'b1; tick(); rst = 1'b0;
    send(8'b1000_0001, 3'd7, 1'b1, "rr_81_a");
    send(8'b1000_0001, 3'd0, 1'b1, "rr_81_b");
    send(8'b1000_0001, 3'd7, 1'b1, "rr_81_c");
    // An empty request leaves the pointer at 7, so the next winner is 0.
    send(8'h00,        3'd0, 1'b0, "rr_zero");
    send(8'b1000_0001, 3'd0, 1'b1, "rr_after_zero");
    send(8'h14,        3'd4, 1'b1, "rr_14");
    send(8'h14,        3'd2, 1'b1, "rr_14b");
`else
    // Fixed mode: the MSB wins every time.
    for (int k = 0; k < 3; k++) begin
      send(8'hFF, 3'd7, 1'b1, "fix_ff");
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
